cn_bank_arbiter: RTL and testbench
==================================

# cn_bank_arbiter

Controller that owns a bank of WIDTH C/N-style flip-flop cells and shares it between two requesters. Each requester issues commands over a valid/ready handshake. A command names one cell, a C/N operation and a repeat count. The block arbitrates round-robin, sequences the operation onto the selected cell for the requested number of cycles, then signals completion. It sits between software-visible command sources and the flip-flop storage, so no requester ever drives cell c/n inputs directly.

## Interface
- WIDTH, 8, number of C/N cells in the bank
- IDXW, 3, cell index width (2^IDXW >= WIDTH)
- CNTW, 4, repeat-count width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge)
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle when high with valid
- req0_c, req0_n  in  1 each  requester 0 C/N operation code
- req0_idx  in  IDXW  requester 0 target cell
- req0_cnt  in  CNTW  requester 0 number of apply cycles
- req1_valid, req1_ready, req1_c, req1_n, req1_idx, req1_cnt  same as requester 0, for requester 1
- q  out  WIDTH  cell states
- qbar  out  WIDTH  bitwise complement of q, always
- busy  out  1  high in APPLY and DONE
- owner  out  1  requester index of the command in progress (last accepted)
- done  out  1  one-cycle completion pulse

## Operation
- Cell rule, per cycle, for the addressed cell:
  - n=0: hold.
  - n=1, c=0: clear to 0.
  - n=1, c=1: toggle.
  - Equivalently, q+ = q ? ~n : (n & c).
  - All non-addressed cells hold.
- FSM states are IDLE, APPLY and DONE.
- IDLE:
  - Ready is asserted combinationally to the arbitration winner only; the loser sees ready=0.
  - Winner: if exactly one valid, that requester wins. If both are valid, the requester not served last wins (priority pointer).
  - On valid&ready, latch c, n, idx and cnt, set owner, and go to APPLY (cnt>0) or DONE (cnt=0).
- APPLY:
  - Each cycle, apply the latched operation to cell idx and decrement the remaining count.
  - After the apply with remaining==1, go to DONE.
  - No ready is asserted in this state.
- DONE:
  - done=1 for exactly one cycle.
  - The priority pointer is set so that owner has lower priority next time.
  - Return to IDLE. No ready is asserted in this state.
- Out-of-range idx (idx >= WIDTH): the command is accepted and sequenced normally (same cycle count, done pulse), but no cell changes.
- cnt=0: the command is accepted, the bank is untouched, and DONE follows immediately.
- Requester inputs are sampled only at acceptance. Later changes do not affect the command in progress.
- Reset values (reset==0 at a clock edge):
  - q=0 and qbar=all ones
  - state=IDLE, busy=0, done=0, owner=0
  - priority pointer favours requester 0
  - ready outputs are 0 during the reset cycle
- Reset mid-operation aborts the command. No done pulse is issued and the bank clears.

## Timing
- Acceptance edge is T. Apply edges are T+1 … T+cnt. Each q change is visible after its apply edge.
- done is high in the cycle following the last apply edge (cnt>0), or in the cycle after T (cnt=0).
- Next acceptance is possible at edge T+cnt+2 at the earliest, giving cnt+2 cycles per command (2 for cnt=0).
- busy rises in the cycle after T and falls in the cycle after DONE.
- ready depends combinationally on valid and the priority pointer in IDLE. There is no combinational path from ready back to valid.
- With both requesters continuously valid, grants alternate 0,1,0,1… after reset.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with req0_valid=1 -> q=0x00, qbar=0xFF, busy=0, done=0, req0_ready=0. Release reset -> req0 accepted on the first IDLE edge.
- **Toggle count:** req0 {c=1,n=1,idx=3,cnt=3} from q=0x00 -> bit3 goes 1,0,1 on successive edges; final q=0x08; done pulses once, 4 cycles after acceptance.
- **Clear and hold:** preload q=0xFF via toggles, then req1 {c=0,n=1,idx=7,cnt=1} -> q=0x7F. Then req1 {c=1,n=0,idx=0,cnt=5} -> q unchanged at 0x7F, done after 6 cycles.
- **Contention:** req0 and req1 both valid continuously with cnt=1 -> accepted owners 0,1,0,1; the loser's ready stays 0 while the other's command is in APPLY/DONE.
- **Boundaries:**
  - cnt=0 -> done in the cycle after acceptance, q unchanged.
  - idx=8 with WIDTH=8, cnt=2 -> q unchanged, done after 3 cycles.
- **Reset mid-operation:** req0 {toggle, idx=1, cnt=10}, assert reset after the 4th apply -> q=0x00 on that edge, no done pulse, FSM in IDLE, req0 has priority afterwards.

Source files
------------

// File: rtl/cn_bank_arbiter.sv
// Round-robin owner of a WIDTH-cell C/N flip-flop bank: accepts one command, applies it cnt cycles, pulses done.
// Latency cnt+2 cycles per command; ready only in IDLE to the arbitration winner, so the loser simply waits.
module cn_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_c,
    input  logic             req0_n,
    input  logic [IDXW-1:0]  req0_idx,
    input  logic [CNTW-1:0]  req0_cnt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_c,
    input  logic             req1_n,
    input  logic [IDXW-1:0]  req1_idx,
    input  logic [CNTW-1:0]  req1_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             owner,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t            state_q, state_d;
    logic              c_q, c_d, n_q, n_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   rem_q, rem_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [WIDTH-1:0]  bank_q, bank_d;
    logic              grant1;
    logic              accept;

    // prio_q names the requester that wins a tie.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || prio_q);
        req0_ready = reset && (state_q == IDLE) && req0_valid && !grant1;
        req1_ready = reset && (state_q == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant1;
                    c_d     = grant1 ? req1_c   : req0_c;
                    n_d     = grant1 ? req1_n   : req0_n;
                    idx_d   = grant1 ? req1_idx : req0_idx;
                    rem_d   = grant1 ? req1_cnt : req0_cnt;
                    state_d = ((grant1 ? req1_cnt : req0_cnt) != '0) ? APPLY : DONE;
                end
            end
            APPLY: begin
                // An index past the bank matches no cell, so the command still times out normally.
                for (int i = 0; i < WIDTH; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        bank_d[i] = bank_q[i] ? ~n_q : (n_q & c_q);
                    end
                end
                rem_d = rem_q - 1'b1;
                if (rem_q == CNTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            idx_q   <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            bank_q  <= bank_d;
        end
    end

    assign q     = bank_q;
    assign qbar  = ~bank_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign owner = owner_q;

endmodule

// File: tb/tb_cn_bank_arbiter.sv
// Randomised + directed bench for cn_bank_arbiter, scoreboarded against a command-level model.
module tb_cn_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req0_c = 1'b0, req0_n = 1'b0;
    logic       req1_valid = 1'b0, req1_c = 1'b0, req1_n = 1'b0;
    logic [3:0] req0_idx = '0, req1_idx = '0;
    logic [3:0] req0_cnt = '0, req1_cnt = '0;
    logic       req0_ready, req1_ready;
    logic [7:0] q, qbar;
    logic       busy, owner, done;

    cn_bank_arbiter #(.WIDTH(8), .IDXW(4), .CNTW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_c(req0_c), .req0_n(req0_n),
        .req0_idx(req0_idx), .req0_cnt(req0_cnt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_c(req1_c), .req1_n(req1_n),
        .req1_idx(req1_idx), .req1_cnt(req1_cnt),
        .q(q), .qbar(qbar), .busy(busy), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         period;
        bit         owner;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    int   p = 0;
    bit   acc [2];

    // Reference model state: the command in flight plus the bank value it started from.
    logic [7:0] m_base = '0;
    bit         m_c = 0, m_n = 0;
    int         m_idx = 0, m_cnt = 0, m_t = 0, m_idle_from = 0;
    bit         m_last = 1'b1;
    bit         m_owner = 1'b0;

    function automatic logic [7:0] apply_k(input logic [7:0] base, input bit c, input bit n,
                                           input int idx, input int k);
        logic [7:0] r;
        r = base;
        if (idx < 8 && k > 0 && n) begin
            if (!c) r[idx] = 1'b0;
            else    r[idx] = base[idx] ^ (k % 2 == 1);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s period=%0d got=%0h want=%0h", name, p, got, want);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding command.
    always @(negedge clk) begin
        if (done !== 1'b0) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL spurious_done period=%0d got done=%b want no pending command", p + 1, done);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.period != p + 1 || mon_e.owner !== owner || mon_e.q !== q) begin
                    mismatched++;
                    $display("FAIL done_record got period=%0d owner=%b q=%h want period=%0d owner=%b q=%h",
                             p + 1, owner, q, mon_e.period, mon_e.owner, mon_e.q);
                end
            end
        end
    end

    initial begin : model
        int k;
        bit idle, r0e, r1e, w;
        logic [7:0] exp_q, exp_qbar;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            p++;
            k = p - m_t;
            if (k < 0) k = 0;
            if (k > m_cnt) k = m_cnt;
            exp_q    = apply_k(m_base, m_c, m_n, m_idx, k);
            exp_qbar = ~exp_q;
            idle = (p >= m_idle_from);
            r0e  = idle && reset && req0_valid && (!req1_valid || m_last);
            r1e  = idle && reset && req1_valid && (!req0_valid || !m_last);
            chk("q", {24'd0, q}, {24'd0, exp_q});
            chk("qbar", {24'd0, qbar}, {24'd0, exp_qbar});
            chk("busy", {31'd0, busy}, {31'd0, !idle});
            chk("owner", {31'd0, owner}, {31'd0, m_owner});
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, r0e});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, r1e});
            if (sb.size() > 0 && sb[0].period < p) begin
                compared++;
                mismatched++;
                $display("FAIL missing_done period=%0d got no pulse want pulse at period %0d", p, sb[0].period);
                void'(sb.pop_front());
            end
            if (!reset) begin
                m_base = '0; m_cnt = 0; m_t = 0; m_idle_from = p + 1;
                m_last = 1'b1; m_owner = 1'b0;
                sb.delete();
            end else if (r0e || r1e) begin
                w      = r1e;
                m_base = exp_q;
                m_c    = w ? req1_c : req0_c;
                m_n    = w ? req1_n : req0_n;
                m_idx  = int'(w ? req1_idx : req0_idx);
                m_cnt  = int'(w ? req1_cnt : req0_cnt);
                m_t    = p + 1;
                m_idle_from = p + m_cnt + 2;
                m_owner = w;
                m_last  = w;
                e.period = p + 1 + m_cnt;
                e.owner  = w;
                e.q      = apply_k(m_base, m_c, m_n, m_idx, m_cnt);
                sb.push_back(e);
                acc[w] = 1'b1;
            end
        end
    end

    task automatic set_req(input int r, input bit v, input bit c, input bit n, input int idx, input int cnt);
        if (r == 0) begin
            req0_valid = v; req0_c = c; req0_n = n; req0_idx = 4'(idx); req0_cnt = 4'(cnt);
        end else begin
            req1_valid = v; req1_c = c; req1_n = n; req1_idx = 4'(idx); req1_cnt = 4'(cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int r);
        int n;
        n = 0;
        acc[r] = 1'b0;
        while (!acc[r] && n < 60) begin
            tick();
            n++;
        end
        compared++;
        if (!acc[r]) begin
            mismatched++;
            $display("FAIL accept_timeout req%0d got no acceptance want acceptance within 60 cycles", r);
        end
    endtask

    task automatic do_cmd(input int r, input bit c, input bit n, input int idx, input int cnt);
        set_req(r, 1'b1, c, n, idx, cnt);
        wait_acc(r);
        set_req(r, 1'b0, c, n, idx, cnt);
        repeat (cnt + 1) tick();
    endtask

    initial begin : stim
        set_req(0, 1'b1, 1'b1, 1'b1, 3, 3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        do_cmd(0, 1'b1, 1'b1, 3, 3);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) do_cmd(0, 1'b1, 1'b1, i, 1);
        end
        do_cmd(1, 1'b0, 1'b1, 7, 1);
        do_cmd(1, 1'b1, 1'b0, 0, 5);
        do_cmd(0, 1'b1, 1'b1, 2, 0);
        do_cmd(1, 1'b1, 1'b1, 8, 2);
        // Both requesters hold valid: grants must alternate.
        set_req(0, 1'b1, 1'b1, 1'b1, 4, 1);
        set_req(1, 1'b1, 1'b1, 1'b1, 5, 1);
        repeat (14) tick();
        set_req(0, 1'b0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (4) tick();
        set_req(0, 1'b1, 1'b1, 1'b1, 1, 10);
        wait_acc(0);
        set_req(0, 1'b0, 1'b1, 1'b1, 1, 10);
        repeat (4) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b1, 6, 0);
        set_req(1, 1'b1, 1'b1, 1'b1, 6, 0);
        repeat (8) tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_req(0, ($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 9), $urandom_range(0, 5));
            set_req(1, ($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 9), $urandom_range(0, 5));
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (30) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
